div_iter_exc: RTL and testbench

- Parametrised multicycle integer divider for the CPU execute stage (multdiv path). Generalises the fixed 32-bit divisor zero check.
- Restoring shift-subtract, one quotient bit per cycle, signed or unsigned.
- Flags divide-by-zero as an exception with early completion.
- Provides a start/ready handshake to the pipeline stall logic.

---
 rtl/div_pkg.sv | 16 +
 rtl/divisor_zero_detect.sv | 11 +
 rtl/div_iter_exc.sv | 162 ++++++++++++++++
 tb/tb_div_iter_exc.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and counter sizing.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Iteration counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/divisor_zero_detect.sv
// Combinational zero detect on a divisor operand of arbitrary width.
module divisor_zero_detect #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic             is_zero_c
);

  assign is_zero_c = ~|value;

endmodule

// File: rtl/div_iter_exc.sv
// Multicycle restoring divider, one quotient bit per cycle, with divide-by-zero
// exception, abort-on-restart and a start/ready handshake for pipeline stalls.
module div_iter_exc
  import div_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
);

  localparam int unsigned         CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             exception_q, exception_d;
  logic             result_rdy_q, result_rdy_d;
  logic             busy_q, busy_d;

  logic             divisor_zero_c;
  logic             dividend_neg, divisor_neg;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             trial_ok;

  divisor_zero_detect #(.WIDTH(WIDTH)) u_zero_detect (
    .value     (divisor),
    .is_zero_c (divisor_zero_c)
  );

  // Operand magnitudes; the sign terms fold to zero in the unsigned build.
  always_comb begin
    dividend_neg = SIGNED && dividend[WIDTH-1];
    divisor_neg  = SIGNED && divisor[WIDTH-1];
    dividend_mag = dividend_neg ? -dividend : dividend;
    divisor_mag  = divisor_neg  ? -divisor  : divisor;
  end

  // Partial remainder is always below the divisor, so WIDTH+1 bits hold the trial.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvsr_q};
    trial_ok = ~trial[WIDTH];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvsr_d       = dvsr_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
    exception_d  = exception_q;
    result_rdy_d = 1'b0;

    case (state_q)
      RUN: begin
        rem_d = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], trial_ok};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d   = q_neg_q ? -quo_q : quo_q;
        remainder_d  = r_neg_q ? -rem_q : rem_q;
        exception_d  = 1'b0;
        result_rdy_d = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A start pulse wins in every state and silently drops any operation in flight.
    if (ctrl_div) begin
      dvsr_d  = divisor_mag;
      quo_d   = dividend_mag;
      rem_d   = '0;
      cnt_d   = '0;
      q_neg_d = dividend_neg ^ divisor_neg;
      r_neg_d = dividend_neg;
      if (divisor_zero_c) begin
        quotient_d   = '0;
        remainder_d  = '0;
        exception_d  = 1'b1;
        result_rdy_d = 1'b1;
        state_d      = DONE;
      end else begin
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        exception_d  = 1'b0;
        result_rdy_d = 1'b0;
        state_d      = RUN;
      end
    end

    busy_d = (state_d == RUN) || (state_d == FIX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvsr_q       <= '0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      exception_q  <= 1'b0;
      result_rdy_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvsr_q       <= dvsr_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
      exception_q  <= exception_d;
      result_rdy_q <= result_rdy_d;
      busy_q       <= busy_d;
    end
  end

  assign quotient   = quotient_q;
  assign remainder  = remainder_q;
  assign exception  = exception_q;
  assign result_rdy = result_rdy_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_div_iter_exc.sv
// Bench for div_iter_exc: a 32-bit signed and an 8-bit unsigned instance checked
// against arithmetic reference results, latency, abort and reset behaviour.
module tb_div_iter_exc;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_div;
  logic [31:0] dividend, divisor;
  logic [31:0] quotient, remainder;
  logic        exception, result_rdy, busy;
  logic        ctrl8;
  logic [7:0]  a8, b8;
  logic [7:0]  q8, r8;
  logic        exc8, rdy8, busy8;

  int total = 0;
  int bad   = 0;

  div_iter_exc #(.WIDTH(32), .SIGNED(1'b1)) dut32 (
    .clock(clock), .reset(reset), .ctrl_div(ctrl_div), .dividend(dividend),
    .divisor(divisor), .quotient(quotient), .remainder(remainder),
    .exception(exception), .result_rdy(result_rdy), .busy(busy)
  );

  div_iter_exc #(.WIDTH(8), .SIGNED(1'b0)) dut8 (
    .clock(clock), .reset(reset), .ctrl_div(ctrl8), .dividend(a8),
    .divisor(b8), .quotient(q8), .remainder(r8),
    .exception(exc8), .result_rdy(rdy8), .busy(busy8)
  );

  always #5 clock = ~clock;

  // Reference: truncating signed division in 64 bits, so most-negative / -1 wraps cleanly.
  function automatic void model32(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
    longint sa, sb, sq, sr;
    if (b == 32'd0) begin
      q = '0; r = '0; e = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q = sq[31:0]; r = sr[31:0]; e = 1'b0;
    end
  endfunction

  // Caller sits 1 time unit after an edge; returns 1 unit after the sampling edge.
  task automatic start32(input logic [31:0] a, input logic [31:0] b);
    ctrl_div = 1'b1; dividend = a; divisor = b;
    @(posedge clock); #1;
    ctrl_div = 1'b0;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    ctrl8 = 1'b1; a8 = a; b8 = b;
    @(posedge clock); #1;
    ctrl8 = 1'b0;
  endtask

  task automatic wait_rdy32(output int lat, output bit seen);
    lat = -1; seen = 1'b0;
    for (int k = 0; k <= 80; k++) begin
      if (result_rdy) begin lat = k; seen = 1'b1; break; end
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_rdy8(output int lat, output bit seen);
    lat = -1; seen = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (rdy8) begin lat = k; seen = 1'b1; break; end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    total++;
    if ({quotient, remainder, exception, result_rdy, busy} !== 67'd0) begin
      bad++;
      $display("FAIL reset32: got q=%h r=%h e=%b rdy=%b busy=%b, want all zero",
               quotient, remainder, exception, result_rdy, busy);
    end
    total++;
    if ({q8, r8, exc8, rdy8, busy8} !== 19'd0) begin
      bad++;
      $display("FAIL reset8: got q=%h r=%h e=%b rdy=%b busy=%b, want all zero",
               q8, r8, exc8, rdy8, busy8);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [4], tb [4], tq [4], tr [4];
    int lat; bit seen;
    ta[0] = 32'd7;         tb[0] = 32'd2;         tq[0] = 32'd3;         tr[0] = 32'd1;
    ta[1] = -32'sd7;       tb[1] = 32'd2;         tq[1] = 32'hFFFFFFFD;  tr[1] = 32'hFFFFFFFF;
    ta[2] = 32'd7;         tb[2] = -32'sd2;       tq[2] = 32'hFFFFFFFD;  tr[2] = 32'd1;
    ta[3] = 32'h80000000;  tb[3] = 32'hFFFFFFFF;  tq[3] = 32'h80000000;  tr[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      start32(ta[i], tb[i]);
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL dir%0d_busy: got %b want 1", i, busy);
      end
      wait_rdy32(lat, seen);
      total++;
      if (!seen || lat != 33) begin
        bad++; $display("FAIL dir%0d_latency: got %0d want 33", i, lat);
      end
      total++;
      if ({quotient, remainder, exception} !== {tq[i], tr[i], 1'b0}) begin
        bad++;
        $display("FAIL dir%0d_result: got q=%h r=%h e=%b want q=%h r=%h e=0",
                 i, quotient, remainder, exception, tq[i], tr[i]);
      end
      @(posedge clock); #1;
      total++;
      if ({result_rdy, busy, quotient, remainder} !== {2'b00, tq[i], tr[i]}) begin
        bad++;
        $display("FAIL dir%0d_hold: got rdy=%b busy=%b q=%h r=%h want rdy=0 busy=0 q=%h r=%h",
                 i, result_rdy, busy, quotient, remainder, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    bit busy_seen;
    start32(32'd5, 32'd0);
    busy_seen = busy;
    total++;
    if ({result_rdy, exception, quotient, remainder} !== {2'b11, 64'd0}) begin
      bad++;
      $display("FAIL div0_result: got rdy=%b e=%b q=%h r=%h want rdy=1 e=1 q=0 r=0",
               result_rdy, exception, quotient, remainder);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      busy_seen |= busy;
    end
    total++;
    if ({result_rdy, exception, busy_seen} !== 3'b010) begin
      bad++;
      $display("FAIL div0_after: got rdy=%b e=%b busy_seen=%b want rdy=0 e=1 busy_seen=0",
               result_rdy, exception, busy_seen);
    end
  endtask

  task automatic test_abort();
    int pulses, lat;
    logic [31:0] q_cap, r_cap;
    pulses = 0; lat = -1; q_cap = '0; r_cap = '0;
    start32(32'd100, 32'd3);
    for (int k = 1; k < 10; k++) begin
      if (result_rdy) pulses++;
      @(posedge clock); #1;
    end
    start32(32'd9, 32'd4);
    for (int k = 0; k <= 40; k++) begin
      if (result_rdy) begin
        pulses++;
        if (lat < 0) begin lat = k; q_cap = quotient; r_cap = remainder; end
      end
      @(posedge clock); #1;
    end
    total++;
    if (pulses != 1 || lat != 33) begin
      bad++; $display("FAIL abort_timing: got pulses=%0d lat=%0d want pulses=1 lat=33", pulses, lat);
    end
    total++;
    if ({q_cap, r_cap} !== {32'd2, 32'd1}) begin
      bad++; $display("FAIL abort_result: got q=%h r=%h want q=2 r=1", q_cap, r_cap);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    start32(32'd100, 32'd3);
    repeat (4) begin @(posedge clock); #1; end
    #1 reset = 1'b1;
    #1;
    total++;
    if ({quotient, remainder, exception, result_rdy, busy} !== 67'd0) begin
      bad++;
      $display("FAIL reset_mid: got q=%h r=%h e=%b rdy=%b busy=%b want all zero",
               quotient, remainder, exception, result_rdy, busy);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (result_rdy || busy) pulses++;
      @(posedge clock); #1;
    end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", pulses);
    end
  endtask

  task automatic test_unsigned8();
    int lat, want_lat; bit seen;
    logic [7:0] a, b, eq, er;
    logic ee;
    start8(8'd200, 8'd7);
    wait_rdy8(lat, seen);
    total++;
    if (!seen || lat != 9 || {q8, r8, exc8} !== {8'd28, 8'd4, 1'b0}) begin
      bad++;
      $display("FAIL u8_200_7: got lat=%0d q=%0d r=%0d e=%b want lat=9 q=28 r=4 e=0",
               lat, q8, r8, exc8);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      a = 8'($urandom);
      b = (i % 5 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (b == 8'd0) begin eq = '0; er = '0; ee = 1'b1; want_lat = 0; end
      else begin eq = a / b; er = a % b; ee = 1'b0; want_lat = 9; end
      start8(a, b);
      wait_rdy8(lat, seen);
      total++;
      if (!seen || lat != want_lat || {q8, r8, exc8} !== {eq, er, ee}) begin
        bad++;
        $display("FAIL u8_rand %0d/%0d: got lat=%0d q=%0d r=%0d e=%b want lat=%0d q=%0d r=%0d e=%b",
                 a, b, lat, q8, r8, exc8, want_lat, eq, er, ee);
      end
    end
  endtask

  task automatic test_random32();
    int lat, want_lat; bit seen;
    logic [31:0] a, b, eq, er;
    logic ee;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock); #1;
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        4:       b = 32'h80000000;
        default: b = 32'($urandom);
      endcase
      model32(a, b, eq, er, ee);
      want_lat = (b == 32'd0) ? 0 : 33;
      start32(a, b);
      wait_rdy32(lat, seen);
      total++;
      if (!seen || lat != want_lat || {quotient, remainder, exception} !== {eq, er, ee}) begin
        bad++;
        $display("FAIL rand32 %h/%h: got lat=%0d q=%h r=%h e=%b want lat=%0d q=%h r=%h e=%b",
                 a, b, lat, quotient, remainder, exception, want_lat, eq, er, ee);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit seen;
    @(posedge clock); #1;
    start32(32'd1000, 32'd7);
    wait_rdy32(lat, seen);
    total++;
    if (!seen || {quotient, remainder} !== {32'd142, 32'd6}) begin
      bad++; $display("FAIL b2b_first: got q=%h r=%h want q=8e r=6", quotient, remainder);
    end
    start32(-32'sd1000, 32'd7);
    total++;
    if ({result_rdy, busy} !== 2'b01) begin
      bad++; $display("FAIL b2b_pulse_end: got rdy=%b busy=%b want rdy=0 busy=1", result_rdy, busy);
    end
    wait_rdy32(lat, seen);
    total++;
    if (!seen || lat != 33 || {quotient, remainder, exception} !== {-32'sd142, -32'sd6, 1'b0}) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d q=%h r=%h e=%b want lat=33 q=ffffff72 r=fffffffa e=0",
               lat, quotient, remainder, exception);
    end
    start32(32'd9, 32'd0);
    total++;
    if ({result_rdy, exception, busy, quotient} !== {3'b110, 32'd0}) begin
      bad++;
      $display("FAIL b2b_zero: got rdy=%b e=%b busy=%b q=%h want rdy=1 e=1 busy=0 q=0",
               result_rdy, exception, busy, quotient);
    end
  endtask

  initial begin
    reset = 1'b1;
    ctrl_div = 1'b0; dividend = '0; divisor = '0;
    ctrl8 = 1'b0; a8 = '0; b8 = '0;
    #1;
    test_reset();
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    test_directed();
    test_div_zero();
    test_abort();
    test_reset_mid();
    test_unsigned8();
    test_random32();
    test_back_to_back();
    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
